branch_target_predictor: RTL and testbench

- Predicts branch direction and target in IF from a direct-mapped BTB with 2-bit saturating counters.
- In EX it receives the resolved outcome from the branch decision logic (BranchE), trains the table and flags mispredicts.
- It supplies PredTakenF/PredTargetF to NPC selection and MispredictE/RedirectPCE to the hazard unit.

---
 rtl/branch_target_predictor.sv | 83 ++++++++
 tb/tb_branch_target_predictor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with 2-bit counters, IF lookup and EX training
// Lookup reads current table contents; training lands on the clock edge (read-before-write).
module branch_target_predictor #(
  parameter int ENTRIES = 64,
  localparam int IDX_W = $clog2(ENTRIES),
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        UpdateE,
  input  logic [31:0] PCE,
  input  logic        BranchE,
  input  logic [31:0] BrTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE,
  output logic [31:0] BrCount,
  output logic [31:0] MissCount
);

  logic             valid_q  [ENTRIES];
  logic [1:0]       cnt_q    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit;
  logic             unused_pc_bits;

  assign f_idx = PCF[IDX_W+1:2];
  assign f_tag = PCF[31:IDX_W+2];
  assign e_idx = PCE[IDX_W+1:2];
  assign e_tag = PCE[31:IDX_W+2];
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign PredTakenF  = f_hit && cnt_q[f_idx][1];
  assign PredTargetF = PredTakenF ? target_q[f_idx] : 32'd0;

  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  // Target mismatch only matters when both prediction and outcome are taken.
  assign MispredictE = UpdateE &&
                       ((PredTakenE != BranchE) ||
                        (PredTakenE && BranchE && (PredTargetE != BrTargetE)));

  assign RedirectPCE = !UpdateE ? 32'd0 :
                       BranchE  ? BrTargetE : PCE + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= 2'b00;
      end
      BrCount   <= 32'd0;
      MissCount <= 32'd0;
    end else if (UpdateE) begin
      BrCount   <= BrCount + 32'd1;
      MissCount <= MissCount + {31'd0, MispredictE};
      if (e_hit) begin
        if (BranchE) begin
          if (cnt_q[e_idx] != 2'b11) cnt_q[e_idx] <= cnt_q[e_idx] + 2'b01;
          target_q[e_idx] <= BrTargetE;
        end else if (cnt_q[e_idx] != 2'b00) begin
          cnt_q[e_idx] <= cnt_q[e_idx] - 2'b01;
        end
      end else if (BranchE) begin
        // Taken miss evicts whatever occupies the slot; a not-taken miss never allocates.
        valid_q[e_idx]  <= 1'b1;
        tag_q[e_idx]    <= e_tag;
        target_q[e_idx] <= BrTargetE;
        cnt_q[e_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - directed literal checks plus randomized run against a table model
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PCF = '0;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        UpdateE = 1'b0;
  logic [31:0] PCE = '0;
  logic        BranchE = 1'b0;
  logic [31:0] BrTargetE = '0;
  logic        PredTakenE = 1'b0;
  logic [31:0] PredTargetE = '0;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
  logic [31:0] BrCount;
  logic [31:0] MissCount;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 0;

  branch_target_predictor #(.ENTRIES(64)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .UpdateE(UpdateE), .PCE(PCE), .BranchE(BranchE), .BrTargetE(BrTargetE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .MispredictE(MispredictE),
    .RedirectPCE(RedirectPCE), .BrCount(BrCount), .MissCount(MissCount)
  );

  always #5 clk = ~clk;

  // Reference table: slot = (pc / 4) mod 64, tag = pc / 256.
  bit          m_valid [64];
  int unsigned m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_cnt   [64];
  logic [31:0] m_br = 0;
  logic [31:0] m_miss = 0;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == pc / 256);
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_cnt[slot(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    return m_taken(pc) ? m_tgt[slot(pc)] : 32'd0;
  endfunction

  function automatic bit m_mis();
    if (!UpdateE) return 1'b0;
    if (PredTakenE != BranchE) return 1'b1;
    return PredTakenE && BranchE && (PredTargetE != BrTargetE);
  endfunction

  function automatic logic [31:0] m_redirect();
    if (!UpdateE) return 32'd0;
    return BranchE ? BrTargetE : PCE + 32'd4;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[i] = 0;
        m_cnt[i] = 0;
      end
      m_br = 0;
      m_miss = 0;
    end else if (UpdateE) begin
      int s;
      s = slot(PCE);
      m_br = m_br + 1;
      if (m_mis()) m_miss = m_miss + 1;
      if (m_hit(PCE)) begin
        if (BranchE) begin
          m_cnt[s] = (m_cnt[s] + 1 > 3) ? 3 : m_cnt[s] + 1;
          m_tgt[s] = BrTargetE;
        end else begin
          m_cnt[s] = (m_cnt[s] - 1 < 0) ? 0 : m_cnt[s] - 1;
        end
      end else if (BranchE) begin
        m_valid[s] = 1;
        m_tag[s] = PCE / 256;
        m_tgt[s] = BrTargetE;
        m_cnt[s] = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      chk("m_pred_taken", {31'd0, PredTakenF}, {31'd0, m_taken(PCF)});
      chk("m_pred_target", PredTargetF, m_target(PCF));
      chk("m_mispredict", {31'd0, MispredictE}, {31'd0, m_mis()});
      chk("m_redirect", RedirectPCE, m_redirect());
      chk("m_br_count", BrCount, m_br);
      chk("m_miss_count", MissCount, m_miss);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pce, input logic br, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptg);
    UpdateE = 1'b1; PCE = pce; BranchE = br; BrTargetE = tgt; PredTakenE = ptk; PredTargetE = ptg;
  endtask

  task automatic idle();
    UpdateE = 1'b0; BranchE = 1'b0; PredTakenE = 1'b0;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    if ($urandom_range(0, 19) == 0) pc = 32'hFFFF_FFFC;
    else if ($urandom_range(0, 9) == 0) pc = $urandom();
    else pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
    return pc;
  endfunction

  initial begin
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    started = 1;

    // Cold start
    PCF = 32'h100; #2;
    chk("cold_taken", {31'd0, PredTakenF}, 32'd0);
    chk("cold_target", PredTargetF, 32'd0);
    chk("cold_brcount", BrCount, 32'd0);
    upd(32'h100, 1, 32'h80, 0, 32'h0); #1;
    chk("cold_mis", {31'd0, MispredictE}, 32'd1);
    chk("cold_redirect", RedirectPCE, 32'h80);
    tick(); idle(); #2;
    chk("cold_misscount", MissCount, 32'd1);
    chk("alloc_taken", {31'd0, PredTakenF}, 32'd1);
    chk("alloc_target", PredTargetF, 32'h80);

    // Saturation and hysteresis
    for (int i = 0; i < 4; i++) begin
      upd(32'h100, 1, 32'h80, 1, 32'h80);
      tick();
    end
    upd(32'h100, 0, 32'h80, 1, 32'h80); #1;
    chk("sat_mis", {31'd0, MispredictE}, 32'd1);
    chk("sat_redirect", RedirectPCE, 32'h104);
    tick(); idle(); #2;
    chk("sat_still_taken", {31'd0, PredTakenF}, 32'd1);
    upd(32'h100, 0, 32'h80, 1, 32'h80);
    tick(); idle(); #2;
    chk("sat_weak_nt", {31'd0, PredTakenF}, 32'd0);
    chk("sat_misscount", MissCount, 32'd3);
    chk("sat_brcount", BrCount, 32'd7);

    // Not-taken miss on an aliasing PC never allocates or evicts
    upd(32'h200, 0, 32'h0, 0, 32'h0); #1;
    chk("ntm_mis", {31'd0, MispredictE}, 32'd0);
    tick(); idle(); PCF = 32'h200; #2;
    chk("ntm_noalloc", {31'd0, PredTakenF}, 32'd0);
    chk("ntm_brcount", BrCount, 32'd8);

    // Target change on a strongly/weakly taken entry
    upd(32'h100, 1, 32'h80, 0, 32'h0);
    tick();
    upd(32'h100, 1, 32'h40, 1, 32'h80); #1;
    chk("tgt_mis", {31'd0, MispredictE}, 32'd1);
    chk("tgt_redirect", RedirectPCE, 32'h40);
    tick(); idle(); PCF = 32'h100; #2;
    chk("tgt_new", PredTargetF, 32'h40);
    chk("tgt_misscount", MissCount, 32'd5);

    // Aliasing eviction and read-before-write
    upd(32'h200, 1, 32'h300, 0, 32'h0); PCF = 32'h200; #2;
    chk("rbw_old", {31'd0, PredTakenF}, 32'd0);
    tick(); idle(); #2;
    chk("rbw_new", PredTargetF, 32'h300);
    PCF = 32'h100; #1;
    chk("alias_evicted", {31'd0, PredTakenF}, 32'd0);

    // PC+4 wraps
    upd(32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0); #1;
    chk("wrap_redirect", RedirectPCE, 32'h0);
    tick();

    // Reset discards a concurrent update
    upd(32'h400, 1, 32'h500, 0, 32'h0); rst = 1'b1;
    tick(); rst = 1'b0; idle(); PCF = 32'h400; #2;
    chk("rst_brcount", BrCount, 32'd0);
    chk("rst_misscount", MissCount, 32'd0);
    chk("rst_no_update", {31'd0, PredTakenF}, 32'd0);
    PCF = 32'h200; #1;
    chk("rst_flushed", {31'd0, PredTakenF}, 32'd0);

    // Randomized run; PredTakenE/PredTargetE usually mirror the model's own prediction
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pce;
      tick();
      rst = ($urandom_range(0, 299) == 0);
      pce = rand_pc();
      UpdateE = ($urandom_range(0, 9) < 7);
      PCE = pce;
      BranchE = $urandom_range(0, 1);
      BrTargetE = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom_range(0, 3) << 6);
      PredTakenE = m_taken(pce);
      PredTargetE = m_target(pce);
      if ($urandom_range(0, 7) == 0) PredTakenE = ~PredTakenE;
      if ($urandom_range(0, 7) == 0) PredTargetE = $urandom_range(0, 3) << 6;
      PCF = ($urandom_range(0, 1) == 0) ? pce : rand_pc();
    end
    tick();
    rst = 1'b0; idle();
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
